// File: rtl/cdb_arbiter_pkg.sv
// System-wide definitions shared by the common-data-bus arbiter:
// functional-unit numbering, register-file and datapath widths, and the
// per-FU completion slot record.
package cdb_arbiter_pkg;

    // Completion ports are numbered in this order.
    typedef enum logic [2:0] {
        FU_ALU = 3'd0,
        FU_LD  = 3'd1,
        FU_ST  = 3'd2,
        FU_FP1 = 3'd3,
        FU_FP2 = 3'd4
    } fu_e;

    localparam int N_FU      = 5;
    localparam int PRF_IDX_W = 6;
    localparam int XLEN      = 32;

    // One buffered completion waiting for its turn on the bus.
    typedef struct packed {
        logic                 occupied;
        logic [PRF_IDX_W-1:0] tag;
        logic [XLEN-1:0]      result;
    } CDB_SLOT;

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin arbiter: searches the request vector starting at
// ptr and wrapping modulo N, returning a one-hot grant and the winner index.
module rr_arbiter #(
    parameter  int N  = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] winner
);

    logic          found;
    logic [IW:0]   sum;
    logic [IW-1:0] idx;

    // First requester at or above ptr (wrapping) wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        sum    = '0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            sum = {1'b0, ptr} + (IW+1)'(k);
            if (sum >= (IW+1)'(N)) begin
                sum = sum - (IW+1)'(N);
            end
            idx = sum[IW-1:0];
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: buffers one completion per functional unit and
// broadcasts at most one per cycle, round-robin, as a registered CDB entry.
module cdb_arbiter #(
    parameter int N_FU   = cdb_arbiter_pkg::N_FU,
    parameter int TAG_W  = cdb_arbiter_pkg::PRF_IDX_W,
    parameter int DATA_W = cdb_arbiter_pkg::XLEN
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [N_FU-1:0]                fu_done,
    input  logic [N_FU-1:0][TAG_W-1:0]     fu_tag,
    input  logic [N_FU-1:0][DATA_W-1:0]    fu_result,
    output logic [N_FU-1:0]                fu_stall,
    output logic                           cdb_valid,
    output logic [TAG_W-1:0]               cdb_tag,
    output logic [DATA_W-1:0]              cdb_value,
    output logic [2:0]                     cdb_fu
);

    import cdb_arbiter_pkg::*;

    localparam int IDX_W = (N_FU > 1) ? $clog2(N_FU) : 1;

    CDB_SLOT          slot_p0 [N_FU];
    logic [N_FU-1:0]  req;
    logic [N_FU-1:0]  grant;
    logic [N_FU-1:0]  capture;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] rr_ptr;
    logic             any_grant;

    rr_arbiter #(
        .N (N_FU)
    ) u_rr (
        .req    (req),
        .ptr    (rr_ptr),
        .grant  (grant),
        .winner (winner)
    );

    // A slot stalls its FU while it still holds an unbroadcast entry; a
    // tag-0 completion (no destination) is never captured.
    always_comb begin
        req       = '0;
        fu_stall  = '0;
        capture   = '0;
        for (int i = 0; i < N_FU; i++) begin
            req[i]      = slot_p0[i].occupied;
            fu_stall[i] = slot_p0[i].occupied && !grant[i];
            capture[i]  = fu_done[i] && !fu_stall[i] && (fu_tag[i] != '0);
        end
        any_grant = |grant;
    end

    // Slot capture / release: a granted slot may be refilled in the same cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_FU; i++) begin
                slot_p0[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_FU; i++) begin
                if (capture[i]) begin
                    slot_p0[i].occupied <= 1'b1;
                    slot_p0[i].tag      <= PRF_IDX_W'(fu_tag[i]);
                    slot_p0[i].result   <= XLEN'(fu_result[i]);
                end else if (grant[i]) begin
                    slot_p0[i].occupied <= 1'b0;
                end
            end
        end
    end

    // Round-robin pointer advances past each winner; idle cycles leave it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rr_ptr <= '0;
        end else if (any_grant) begin
            rr_ptr <= (winner == IDX_W'(N_FU-1)) ? '0 : winner + 1'b1;
        end
    end

    // Registered broadcast: valid pulses per grant, payload holds when idle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cdb_valid <= 1'b0;
            cdb_tag   <= '0;
            cdb_value <= '0;
            cdb_fu    <= '0;
        end else begin
            cdb_valid <= any_grant;
            if (any_grant) begin
                cdb_tag   <= TAG_W'(slot_p0[winner].tag);
                cdb_value <= DATA_W'(slot_p0[winner].result);
                cdb_fu    <= 3'(winner);
            end
        end
    end

endmodule
